lsl8_seq: RTL

- Sequential 8-bit arithmetic/logical shift-left unit, the left-direction counterpart of the team's 8-bit arithmetic right shifter.
- Shifts one bit position per clock under a start/busy/done handshake.
- Reports the last bit shifted out (carry) and signed overflow.
- Sits in the shifter group of the datapath, where a multi-cycle left shift is acceptable in exchange for minimal logic.

---
 rtl/lsl8_seq.sv | 103 ++++++++++
 1 files changed

// File: rtl/lsl8_seq.sv
// lsl8_seq: sequential 8-bit left shifter. It shifts one bit position per clock
// under a start/busy/done handshake, and reports the last bit shifted out and
// signed overflow. Logical and arithmetic left shift are the same operation.
//
// Ports:
//   clk      - system clock, rising-edge active
//   reset_n  - asynchronous active-low reset
//   start    - operation request, sampled only while idle
//   d_in     - operand, captured when start is accepted
//   shamt    - shift amount 0-7, captured when start is accepted
//   d_out    - shift result; intermediate values are visible while shifting
//   carry    - last bit shifted out of bit 7
//   ovf      - sticky signed overflow: the sign changed at some step
//   busy     - high while an operation is in progress (shift and done cycles)
//   done     - one-cycle completion pulse
module lsl8_seq (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] d_in,
    input  logic [2:0] shamt,
    output logic [7:0] d_out,
    output logic       carry,
    output logic       ovf,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] data_q, data_d;
    logic [2:0] cnt_q, cnt_d;
    logic       carry_q, carry_d;
    logic       ovf_q, ovf_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            data_q  <= 8'h00;
            cnt_q   <= 3'd0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        busy    = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    data_d  = d_in;
                    cnt_d   = shamt;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = StShift;
                end
            end
            StShift: begin
                busy = 1'b1;
                if (cnt_q == 3'd0) begin
                    state_d = StDone;
                end else begin
                    data_d  = {data_q[6:0], 1'b0};
                    carry_d = data_q[7];
                    // Sign flips on this step when the two top bits differ.
                    ovf_d   = ovf_q | (data_q[7] ^ data_q[6]);
                    cnt_d   = cnt_q - 3'd1;
                end
            end
            StDone: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign d_out = data_q;
    assign carry = carry_q;
    assign ovf   = ovf_q;

endmodule
